// File: rtl/mux2_arbiter.sv
// Two-requester arbiter that feeds a one-entry registered output stage.
// Ties between the requesters are broken by a pointer that moves to the other side after every transfer.
module mux2_arbiter #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 a_valid,
  input  logic [DATAWIDTH-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATAWIDTH-1:0] b_data,
  output logic                 b_ready,
  output logic                 sel,
  output logic [DATAWIDTH-1:0] d,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic                 d_src
);

  logic [DATAWIDTH-1:0] d_q, d_d;
  logic                 d_valid_q, d_valid_d;
  logic                 d_src_q, d_src_d;
  logic                 prio_q, prio_d;

  logic load;
  logic grant_a;
  logic grant_b;
  logic xfer;

  // The grant depends only on the valids and the pointer; load only gates the ready outputs.
  always_comb begin
    load    = !d_valid_q || d_ready;
    grant_a = a_valid && (!b_valid || prio_q);
    grant_b = b_valid && !grant_a;
    a_ready = Rst && load && grant_a;
    b_ready = Rst && load && grant_b;
    xfer    = a_ready || b_ready;
    sel     = (a_valid || b_valid) ? grant_a : prio_q;
  end

  always_comb begin
    d_d       = d_q;
    d_src_d   = d_src_q;
    d_valid_d = d_valid_q;
    prio_d    = prio_q;
    if (xfer) begin
      d_d       = sel ? a_data : b_data;
      d_src_d   = sel;
      d_valid_d = 1'b1;
      prio_d    = !sel;
    end else if (d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      d_q       <= '0;
      d_src_q   <= 1'b0;
      d_valid_q <= 1'b0;
      prio_q    <= 1'b1;
    end else begin
      d_q       <= d_d;
      d_src_q   <= d_src_d;
      d_valid_q <= d_valid_d;
      prio_q    <= prio_d;
    end
  end

  assign d       = d_q;
  assign d_src   = d_src_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed literal cases followed by random traffic.
// A queue-based reference model and an in-order scoreboard check the DUT on every cycle.
module tb_mux2_arbiter;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          a_valid, b_valid, d_ready;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, sel, d_valid, d_src;
  logic [DW-1:0] d;

  int nchecks = 0;
  int nerr = 0;

  mux2_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .d(d), .d_valid(d_valid), .d_ready(d_ready), .d_src(d_src)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: words accepted but not yet delivered, the word d shows,
  // and which side was served most recently (B at reset, so A wins the first tie).
  logic [DW:0] pend[$];
  logic [DW:0] shown;
  logic        last_a;
  logic        model_ok = 1'b0;
  int          a_skip, b_skip;

  function automatic void expect_now(output logic ea, output logic eb, output logic es);
    logic room, pick_a, pick_b;
    room   = (pend.size() == 0) || d_ready;
    pick_a = a_valid && (!b_valid || !last_a);
    pick_b = b_valid && !pick_a;
    ea = Rst && room && pick_a;
    eb = Rst && room && pick_b;
    es = (a_valid || b_valid) ? pick_a : !last_a;
  endfunction

  always @(posedge Clk) begin
    logic ea, eb, es;
    if (!Rst) begin
      pend.delete();
      shown    = '0;
      last_a   = 1'b0;
      a_skip   = 0;
      b_skip   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      expect_now(ea, eb, es);
      if (pend.size() != 0 && d_ready) void'(pend.pop_front());
      if (ea) begin
        shown = {1'b1, a_data};
        pend.push_back(shown);
        last_a = 1'b1;
        a_skip = 0;
        if (b_valid) b_skip++;
      end else if (eb) begin
        shown = {1'b0, b_data};
        pend.push_back(shown);
        last_a = 1'b0;
        b_skip = 0;
        if (a_valid) a_skip++;
      end
      if (!a_valid) a_skip = 0;
      if (!b_valid) b_skip = 0;
    end
  end

  always @(negedge Clk) begin
    logic ea, eb, es;
    if (model_ok) begin
      expect_now(ea, eb, es);
      chk("a_ready", {31'b0, a_ready}, {31'b0, ea});
      chk("b_ready", {31'b0, b_ready}, {31'b0, eb});
      chk("one_ready", {31'b0, a_ready && b_ready}, 32'd0);
      chk("sel", {31'b0, sel}, {31'b0, es});
      chk("d_valid", {31'b0, d_valid}, {31'b0, pend.size() != 0});
      chk("d_word", {15'b0, d_src, d}, {15'b0, shown});
      if (d_valid && d_ready) begin
        if (pend.size() == 0) chk("drain_expected", 32'd1, 32'd0);
        else chk("drain_order", {15'b0, d_src, d}, {15'b0, pend[0]});
      end
      chk("a_starve", {31'b0, a_skip > 1}, 32'd0);
      chk("b_starve", {31'b0, b_skip > 1}, 32'd0);
    end
  end

  initial begin
    Rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b0;
    a_data = '0; b_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_d", {16'b0, d}, 32'd0);
    chk("rst_d_src", {31'b0, d_src}, 32'd0);
    a_valid = 1'b1; b_valid = 1'b1; d_ready = 1'b1;
    a_data = 16'h1111; b_data = 16'h2222;
    #1;
    chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
    Rst = 1'b1;
    #1;
    chk("first_sel", {31'b0, sel}, 32'd1);
    chk("first_a_ready", {31'b0, a_ready}, 32'd1);

    // Alternating service with both requesters always valid.
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("alt_d", {16'b0, d}, (i % 2 == 0) ? 32'h1111 : 32'h2222);
      chk("alt_src", {31'b0, d_src}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_valid", {31'b0, d_valid}, 32'd1);
    end

    a_valid = 1'b0; b_data = 16'h00B0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bonly_b_ready", {31'b0, b_ready}, 32'd1);
      chk("bonly_a_ready", {31'b0, a_ready}, 32'd0);
      chk("bonly_sel", {31'b0, sel}, 32'd0);
      @(posedge Clk); #1;
      chk("bonly_d", {16'b0, d}, 32'h00B0);
      chk("bonly_src", {31'b0, d_src}, 32'd0);
    end

    // Pointer still favours A after B-only transfers.
    a_valid = 1'b1; a_data = 16'h1234;
    #1;
    chk("prio_a_ready", {31'b0, a_ready}, 32'd1);
    chk("prio_b_ready", {31'b0, b_ready}, 32'd0);
    @(posedge Clk); #1;
    chk("bp_load_d", {16'b0, d}, 32'h1234);
    chk("bp_load_src", {31'b0, d_src}, 32'd1);
    d_ready = 1'b0; b_data = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_d", {16'b0, d}, 32'h1234);
      chk("bp_valid", {31'b0, d_valid}, 32'd1);
      chk("bp_a_ready", {31'b0, a_ready}, 32'd0);
      chk("bp_b_ready", {31'b0, b_ready}, 32'd0);
      @(posedge Clk); #1;
    end
    d_ready = 1'b1;
    #1;
    chk("bp_rel_b_ready", {31'b0, b_ready}, 32'd1);
    chk("bp_rel_a_ready", {31'b0, a_ready}, 32'd0);
    @(posedge Clk); #1;
    chk("bp_rel_d", {16'b0, d}, 32'h5678);
    chk("bp_rel_src", {31'b0, d_src}, 32'd0);

    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge Clk); #1;
    chk("drain_valid", {31'b0, d_valid}, 32'd0);
    chk("drain_hold_d", {16'b0, d}, 32'h5678);

    // Reset while a word is held under back-pressure.
    a_valid = 1'b1; a_data = 16'hAAAA;
    @(posedge Clk); #1;
    a_valid = 1'b0; d_ready = 1'b0;
    @(posedge Clk); #1;
    chk("hold_d", {16'b0, d}, 32'hAAAA);
    Rst = 1'b0;
    @(posedge Clk); #1;
    chk("midrst_valid", {31'b0, d_valid}, 32'd0);
    chk("midrst_d", {16'b0, d}, 32'd0);
    Rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; d_ready = 1'b1;
    a_data = 16'h1111; b_data = 16'h2222;
    #1;
    chk("midrst_a_first", {31'b0, a_ready}, 32'd1);
    chk("midrst_b_ready", {31'b0, b_ready}, 32'd0);
    chk("midrst_sel", {31'b0, sel}, 32'd1);

    for (int i = 0; i < 10000; i++) begin
      @(posedge Clk); #1;
      Rst     = ($urandom_range(0, 499) != 0);
      a_valid = ($urandom_range(0, 99) < 60);
      b_valid = ($urandom_range(0, 99) < 60);
      d_ready = ($urandom_range(0, 99) < 70);
      a_data  = 16'($urandom);
      b_data  = 16'($urandom);
    end

    @(posedge Clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
